// File: rtl/output_stage.sv
// Output stage: collects MAC partial-sum rows per tile pass, accumulates them
// across depth passes in a local ROWS x COLS buffer, and flushes the tile to
// output memory on the last depth pass. Tile_Done pulses once per pass.
module output_stage #(
  parameter int unsigned LANE_W = 16,
  parameter int unsigned COLS   = 4,
  parameter int unsigned ROWS   = 4
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         START_CALC,
  input  logic [3:0]                   ODST,
  input  logic                         FIRST_PASS,
  input  logic                         LAST_PASS,
  input  logic                         PSUM_VALID,
  input  logic [COLS*LANE_W-1:0]       PSUM_ROW,
  output logic                         OWE,
  output logic [4+$clog2(ROWS)-1:0]    OADDR,
  output logic [COLS*LANE_W-1:0]       ODATA,
  output logic                         Tile_Done,
  output logic                         OVR
);

  localparam int unsigned RowW    = $clog2(ROWS);
  localparam int unsigned RowBits = COLS * LANE_W;
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e               state_q;
  logic [3:0]           tile_addr_q;
  logic                 first_q;
  logic                 last_q;
  logic [RowW-1:0]      rc_q;
  logic [RowW-1:0]      wr_q;
  logic [RowBits-1:0]   acc_q [ROWS];

  logic [RowBits-1:0]   acc_row_d;
  logic [RowW-1:0]      wr_nxt;
  logic [RowBits-1:0]   first_row_data;

  // Per-lane accumulate (mod 2^LANE_W) of the incoming beat into the current row.
  always_comb begin
    acc_row_d = '0;
    for (int k = 0; k < COLS; k++) begin
      acc_row_d[k*LANE_W +: LANE_W] = first_q ? PSUM_ROW[k*LANE_W +: LANE_W]
                                     : acc_q[rc_q][k*LANE_W +: LANE_W]
                                       + PSUM_ROW[k*LANE_W +: LANE_W];
    end
    wr_nxt = wr_q + RowW'(1);
    // With a single-row tile, row 0 is the one being accumulated on the final beat.
    first_row_data = (ROWS == 1) ? acc_row_d : acc_q[0];
  end

  // Pass FSM with accumulator buffer and registered memory/handshake outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      tile_addr_q <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      rc_q        <= '0;
      wr_q        <= '0;
      for (int i = 0; i < ROWS; i++) acc_q[i] <= '0;
      OWE         <= 1'b0;
      OADDR       <= '0;
      ODATA       <= '0;
      Tile_Done   <= 1'b0;
      OVR         <= 1'b0;
    end else begin
      Tile_Done <= 1'b0;
      // Beats arriving outside COLLECT are dropped and flagged.
      if (PSUM_VALID && (state_q != StCollect)) OVR <= 1'b1;

      case (state_q)
        StIdle: begin
          if (START_CALC) begin
            state_q     <= StCollect;
            tile_addr_q <= ODST;
            first_q     <= FIRST_PASS;
            last_q      <= LAST_PASS;
            rc_q        <= '0;
          end
        end

        StCollect: begin
          if (!START_CALC) begin
            state_q <= StIdle;
          end else if (PSUM_VALID) begin
            acc_q[rc_q] <= acc_row_d;
            rc_q        <= rc_q + RowW'(1);
            if (rc_q == LastRow) begin
              if (last_q) begin
                // First write row is presented in the cycle right after the final beat.
                state_q <= StWrite;
                wr_q    <= '0;
                OWE     <= 1'b1;
                OADDR   <= {tile_addr_q, {RowW{1'b0}}};
                ODATA   <= first_row_data;
              end else begin
                state_q   <= StDone;
                Tile_Done <= 1'b1;
              end
            end
          end
        end

        StWrite: begin
          if (wr_q == LastRow) begin
            OWE       <= 1'b0;
            state_q   <= StDone;
            Tile_Done <= 1'b1;
          end else begin
            wr_q  <= wr_nxt;
            OADDR <= {tile_addr_q, wr_nxt};
            ODATA <= acc_q[wr_nxt];
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
